// File: rtl/serial_uart_port.sv
// Byte-wide MMIO side to 8N1 UART line pair: 4-deep TX FIFO feeding a serializer,
// synchronized RX deserializer feeding a single holding register with sticky error flags.
module serial_uart_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_FIFO_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic       err_clear_in,
  output logic       overrun_out,
  output logic       frame_err_out,
  output logic       uart_tx_out,
  input  logic       uart_rx_in
);

  localparam int DEPTH = 1 << TX_FIFO_LOG2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TX_FIFO_LOG2:0]   FULL    = (TX_FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [TX_FIFO_LOG2:0]   CNT_ONE = (TX_FIFO_LOG2 + 1)'(1);
  localparam logic [TX_FIFO_LOG2-1:0] PTR_ONE = (TX_FIFO_LOG2)'(1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  logic [7:0]              fifo_mem [DEPTH];
  logic [TX_FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TX_FIFO_LOG2:0]   count, count_next;
  logic                    push, pop;

  // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
  assign push = tx_wren_in && (count != FULL);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tx_ready_out <= 1'b1;
    end else begin
      count        <= count_next;
      tx_ready_out <= (count_next != FULL);
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= tx_data_in;
  end

  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      T_IDLE:  if (count != '0) begin
                 pop     = 1'b1;
                 tx_next = T_START;
               end
      T_START: if (tx_bit_end) tx_next = T_DATA;
      T_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_bit_end) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tx_state <= T_IDLE;
    else
      tx_state <= tx_next;
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_shift    <= '0;
      uart_tx_out <= 1'b1;
    end else begin
      if (tx_state == T_IDLE || tx_bit_end)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 16'd1;
      if (pop) begin
        tx_shift <= fifo_mem[rd_ptr];
        tx_idx   <= '0;
      end else if (tx_state == T_DATA && tx_bit_end) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
      case (tx_state)
        T_START: uart_tx_out <= 1'b0;
        T_DATA:  uart_tx_out <= tx_shift[0];
        default: uart_tx_out <= 1'b1;
      endcase
    end
  end

  logic       sync1, sync2, sync3;
  logic [1:0] warm;
  logic       falling;

  // Edges are only trusted once sync3 holds a real line sample, so a line
  // already low when reset lifts is not mistaken for a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
      warm  <= '0;
    end else begin
      sync1 <= uart_rx_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (warm != 2'd3)
        warm <= warm + 2'd1;
    end
  end

  assign falling = (warm == 2'd3) && sync3 && !sync2;

  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_sample, rx_done, deliver;

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    rx_done   = 1'b0;
    case (rx_state)
      R_IDLE:  if (falling) rx_next = R_START;
      R_START: if (rx_cnt == HALF_LAST) rx_next = sync2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_cnt == BIT_LAST) begin
                 rx_sample = 1'b1;
                 if (rx_idx == 3'd7) rx_next = R_STOP;
               end
      R_STOP:  if (rx_cnt == BIT_LAST) begin
                 rx_done = 1'b1;
                 rx_next = R_IDLE;
               end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rx_state <= R_IDLE;
    else
      rx_state <= rx_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == R_IDLE || rx_next != rx_state || rx_sample)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == R_IDLE)
        rx_idx <= '0;
      else if (rx_sample)
        rx_idx <= rx_idx + 3'd1;
      if (rx_sample)
        rx_shift <= {sync2, rx_shift[7:1]};
    end
  end

  assign deliver = rx_done && sync2;

  // A read in the same cycle as a delivery frees the register, so no overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data_out   <= '0;
      rx_valid_out  <= 1'b0;
      overrun_out   <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      if (deliver && (!rx_valid_out || rx_rden_in)) begin
        rx_data_out  <= rx_shift;
        rx_valid_out <= 1'b1;
      end else if (rx_rden_in && rx_valid_out) begin
        rx_valid_out <= 1'b0;
      end
      if (deliver && rx_valid_out && !rx_rden_in)
        overrun_out <= 1'b1;
      else if (err_clear_in)
        overrun_out <= 1'b0;
      if (rx_done && !sync2)
        frame_err_out <= 1'b1;
      else if (err_clear_in)
        frame_err_out <= 1'b0;
    end
  end

endmodule
